spi_regmap_burst: RTL

Parametrised SPI slave register map, the successor to the fixed-format SPI register block in `spi/`. It oversamples an SPI mode-0 bus in the system `clk` domain and decodes frames of the form `{R/W, address, data word(s)}`. It holds `NUM_REGS` registers of `DATA_W` bits, supports write and read-back, and streams consecutive registers with address auto-increment while `spi_cs_n` stays low. It sits between the SPI pads and the crypto accelerator's control/config registers.

---
 rtl/spi_regmap_burst.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/spi_regmap_burst.sv
// SPI mode-0 slave register map, oversampled in the clk domain; frames are {rw, addr, word(s)}.
// Define SPI_REGMAP_BURST_EN for address auto-increment bursts while spi_cs_n stays low.
module spi_regmap_burst #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 40,
    parameter int NUM_REGS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       spi_sclk,
    input  logic                       spi_cs_n,
    input  logic                       spi_mosi,
    output logic                       spi_miso,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);
    // Bit counter must cover the longer of the address and data fields.
    localparam int MAX_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, WAIT_CS} state_t;

    logic [2:0]        sclk_q;
    logic [1:0]        cs_q, mosi_q;
    state_t            state_q, state_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-2:0] sh_in_q, sh_in_d;
    logic [DATA_W-1:0] sh_out_q, sh_out_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              miso_q, miso_d;
    logic              wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              frame_err_q, frame_err_d;
    logic              sclk_rise, sclk_fall, cs_s, mosi_s;
    logic [DATA_W-1:0] sh_nxt;
    logic [ADDR_W-1:0] addr_nxt;
`ifdef SPI_REGMAP_BURST_EN
    logic [ADDR_W-1:0] addr_inc;
`endif

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W+1)'(NUM_REGS);
    endfunction

    function automatic logic [DATA_W-1:0] reg_at(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (a == ADDR_W'(i)) v = regs_q[i];
        return v;
    endfunction

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_s      = cs_q[1];
    assign mosi_s    = mosi_q[1];
    assign sh_nxt    = {sh_in_q, mosi_s};
    assign addr_nxt  = sh_nxt[ADDR_W-1:0];
`ifdef SPI_REGMAP_BURST_EN
    assign addr_inc  = (addr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : addr_q + 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        sh_in_d     = sh_in_q;
        sh_out_d    = sh_out_q;
        regs_d      = regs_q;
        miso_d      = 1'b0;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;
        if (cs_s && state_q != IDLE) begin
            // A CS rise is clean only before any bit or exactly on a word boundary.
            state_d     = IDLE;
            frame_err_d = (state_q == ADDR) || (state_q == DATA && cnt_q != '0);
        end else begin
            case (state_q)
                IDLE: if (!cs_s) state_d = CMD;
                CMD: if (sclk_rise) begin
                    rw_d    = mosi_s;
                    cnt_d   = '0;
                    state_d = ADDR;
                end
                ADDR: if (sclk_rise) begin
                    sh_in_d = sh_nxt[DATA_W-2:0];
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                        addr_d  = addr_nxt;
                        cnt_d   = '0;
                        state_d = DATA;
                        if (!rw_q) begin
                            sh_out_d    = reg_at(addr_nxt);
                            frame_err_d = !in_range(addr_nxt);
                        end
                    end
                end
                DATA: begin
                    if (!rw_q) begin
                        miso_d = miso_q;
                        if (sclk_fall) begin
                            miso_d   = sh_out_q[DATA_W-1];
                            sh_out_d = sh_out_q << 1;
                        end
                    end
                    if (sclk_rise) begin
                        sh_in_d = sh_nxt[DATA_W-2:0];
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            cnt_d = '0;
                            if (rw_q) begin
                                if (in_range(addr_q)) begin
                                    for (int i = 0; i < NUM_REGS; i++)
                                        if (addr_q == ADDR_W'(i)) regs_d[i] = sh_nxt;
                                    wr_stb_d  = 1'b1;
                                    wr_addr_d = addr_q;
                                end else begin
                                    frame_err_d = 1'b1;
                                end
                            end
`ifdef SPI_REGMAP_BURST_EN
                            addr_d = addr_inc;
                            if (!rw_q) sh_out_d = reg_at(addr_inc);
`else
                            state_d = WAIT_CS;
`endif
                        end
                    end
                end
                WAIT_CS: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // Synchronisers run through reset so the post-reset state reflects the real CS level.
    always_ff @(posedge clk) begin
        sclk_q <= {sclk_q[1:0], spi_sclk};
        cs_q   <= {cs_q[0], spi_cs_n};
        mosi_q <= {mosi_q[0], spi_mosi};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= cs_q[1] ? IDLE : WAIT_CS;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            miso_q      <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            miso_q      <= miso_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
            regs_q      <= regs_d;
        end
        sh_in_q  <= sh_in_d;
        sh_out_q <= sh_out_d;
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign spi_miso  = miso_q;
    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;
endmodule
